el2_walk_sched: RTL and testbench

//   Deterministic scheduler for the el2Omega graph walker. Replaces the walker's free choice

---
 rtl/el2_walk_sched.sv | 142 ++++++++++++++
 tb/tb_el2_walk_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/el2_walk_sched.sv
// Deterministic walk scheduler for the el2Omega walker: one bounded, fair walk per row,
// with sink detection, walk-length capture and a watchdog.
module el2_walk_sched #(
  parameter int ROWMSB   = 1,
  parameter int COLMSB   = ROWMSB + 2,
  parameter int DIGMSB   = 1,
  parameter int MAXPAUSE = 3,
  parameter int STEPMAX  = 64,
  parameter int STEPW    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [COLMSB:0]   col_i,
  output logic              restart_o,
  output logic [ROWMSB:0]   rchoice_o,
  output logic [COLMSB:0]   cchoice_o,
  output logic [DIGMSB:0]   dchoice_o,
  output logic              pause_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [STEPW-1:0]  steps_o
);

  localparam int COLBITS = COLMSB + 1;
  localparam int DIGBITS = DIGMSB + 1;
  localparam int PCW     = $clog2(MAXPAUSE + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WALK   = 3'd2;
  localparam logic [2:0] S_SINK   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ROWMSB:0]   row_q, row_d;
  logic [PCW-1:0]    pause_cnt_q, pause_cnt_d;
  logic [DIGMSB:0]   dig_cnt_q, dig_cnt_d;
  logic [STEPW-1:0]  step_cnt_q, step_cnt_d;
  logic [STEPW-1:0]  steps_q, steps_d;
  logic              err_q, err_d;
  logic [COLMSB:0]   col_prev_q;

  logic [COLMSB:0]   sink_sum;
  logic              sink;
  logic              dstate;
  logic              col_chg;
  logic              in_walk;
  logic              step_max;
  logic [PCW-1:0]    pause_base;
  logic              pause;

  assign sink_sum = col_i + {1'b0, row_q, 1'b0};
  assign sink     = (sink_sum == {COLBITS{1'b1}});
  assign dstate   = col_i[COLMSB] & col_i[0] & (col_i != {1'b1, {COLMSB{1'b0}}});
  assign col_chg  = (col_i != col_prev_q);
  assign in_walk  = (state_q == S_WALK);
  assign step_max = (step_cnt_q == STEPW'(STEPMAX));

  // A freshly entered column starts its pause budget from zero.
  assign pause_base = col_chg ? '0 : pause_cnt_q;
  assign pause      = in_walk & dstate & (pause_base < PCW'(MAXPAUSE));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    pause_cnt_d = pause_cnt_q;
    dig_cnt_d   = dig_cnt_q;
    step_cnt_d  = step_cnt_q;
    steps_d     = steps_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LAUNCH;
          row_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LAUNCH: begin
        step_cnt_d  = '0;
        pause_cnt_d = '0;
        state_d     = S_WALK;
      end
      S_WALK: begin
        pause_cnt_d = pause ? pause_base + PCW'(1) : pause_base;
        if (col_chg && dstate) dig_cnt_d = dig_cnt_q + DIGBITS'(1);
        step_cnt_d = step_max ? step_cnt_q : step_cnt_q + STEPW'(1);
        if (sink) begin
          steps_d = step_cnt_q;
          state_d = S_SINK;
        end else if (step_max) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SINK: begin
        if (row_q == '1) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      pause_cnt_q <= '0;
      dig_cnt_q   <= '0;
      step_cnt_q  <= '0;
      steps_q     <= '0;
      err_q       <= 1'b0;
      col_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      pause_cnt_q <= pause_cnt_d;
      dig_cnt_q   <= dig_cnt_d;
      step_cnt_q  <= step_cnt_d;
      steps_q     <= steps_d;
      err_q       <= err_d;
      col_prev_q  <= col_i;
    end
  end

  assign restart_o = (state_q == S_LAUNCH);
  assign rchoice_o = row_q;
  assign cchoice_o = in_walk ? (col_i + COLBITS'(row_q) + COLBITS'(1)) : '0;
  assign dchoice_o = dig_cnt_q;
  assign pause_o   = pause;
  assign busy_o    = (state_q == S_LAUNCH) || in_walk || (state_q == S_SINK);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = err_q;
  assign steps_o   = steps_q;

endmodule

// File: tb/tb_el2_walk_sched.sv
// Bench for el2_walk_sched: a simple walker model advances one column per unpaused cycle;
// per-walk expectations are queued at sweep start and retired as walks complete.
module tb_el2_walk_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  col_i;
  logic        restart_o;
  logic [1:0]  rchoice_o;
  logic [3:0]  cchoice_o;
  logic [1:0]  dchoice_o;
  logic        pause_o, busy_o, done_o, err_o;
  logic [7:0]  steps_o;

  logic [3:0]  walk_col;
  logic        force_en = 1'b0;
  logic [3:0]  force_col = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int row;
    int sink_col;
    int steps;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  el2_walk_sched dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start_i),
    .col_i     (col_i),
    .restart_o (restart_o),
    .rchoice_o (rchoice_o),
    .cchoice_o (cchoice_o),
    .dchoice_o (dchoice_o),
    .pause_o   (pause_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .steps_o   (steps_o)
  );

  assign col_i = force_en ? force_col : walk_col;

  // Walker model: restart reloads column 0; otherwise step one column toward the jump
  // target unless paused, never beyond 15.
  always @(posedge clk) begin
    if (!rst_n) walk_col <= 4'd0;
    else if (restart_o) walk_col <= 4'd0;
    else if (!pause_o && cchoice_o != walk_col && walk_col != 4'd15) walk_col <= walk_col + 4'd1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Walk length for a row: one cycle per column up to the sink, plus three pause cycles
  // for every digit-state column (odd and >= 9) passed on the way.
  function automatic int exp_steps(input int row);
    int s = 15 - 2 * row;
    int n = s;
    for (int c = 1; c < s; c++) if (c >= 9 && (c % 2) == 1) n += 3;
    return n;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask

  task automatic run_sweep();
    int   cyc = 0;
    bit   have = 0;
    logic [3:0] h1 = 4'd0;
    logic [3:0] h2 = 4'd0;
    for (int r = 0; r < 4; r++) sb.push_back('{row: r, sink_col: 15 - 2 * r, steps: exp_steps(r)});
    pulse_start();
    while (cyc < 400) begin
      if (restart_o || done_o) begin
        if (have) begin
          chk($sformatf("sink_col_row%0d", sb[0].row), int'(h2), sb[0].sink_col);
          chk($sformatf("steps_row%0d", sb[0].row), int'(steps_o), sb[0].steps);
          void'(sb.pop_front());
          have = 0;
        end
        if (done_o) break;
        if (sb.size() == 0) begin
          chk("extra_walk", 1, 0);
        end else begin
          chk($sformatf("rchoice_walk%0d", sb[0].row), int'(rchoice_o), sb[0].row);
          have = 1;
        end
      end
      h2 = h1;
      h1 = col_i;
      @(negedge clk);
      cyc++;
    end
    chk("sweep_done", int'(done_o), 1);
    chk("sweep_sb_empty", sb.size(), 0);
  endtask

  initial begin
    int n;
    // Reset state
    @(negedge clk);
    chk("rst_restart", int'(restart_o), 0);
    chk("rst_rchoice", int'(rchoice_o), 0);
    chk("rst_cchoice", int'(cchoice_o), 0);
    chk("rst_dchoice", int'(dchoice_o), 0);
    chk("rst_pause", int'(pause_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_steps", int'(steps_o), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Full sweep with the walker model
    run_sweep();
    chk("sweep_err", int'(err_o), 0);
    chk("sweep_busy", int'(busy_o), 0);
    chk("sweep_dchoice", int'(dchoice_o), 2);
    repeat (2) @(negedge clk);
    chk("done_held", int'(done_o), 1);

    // Watchdog with the column stuck at 0, started from DONE
    force_en  = 1'b1;
    force_col = 4'd0;
    pulse_start();
    chk("redo_restart", int'(restart_o), 1);
    chk("redo_rchoice", int'(rchoice_o), 0);
    chk("redo_done", int'(done_o), 0);
    chk("redo_err", int'(err_o), 0);
    @(negedge clk);
    chk("wd_cchoice", int'(cchoice_o), 1);
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("wd_walk_cycles", n, 65);
    chk("wd_err", int'(err_o), 1);
    chk("wd_done", int'(done_o), 1);
    chk("wd_steps_held", int'(steps_o), exp_steps(3));

    // Fairness: column held in a digit state during row 0
    force_col = 4'd9;
    @(negedge clk);
    pulse_start();
    chk("fair_restart", int'(restart_o), 1);
    chk("fair_err_clr", int'(err_o), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fair_pause_c%0d", i), int'(pause_o), (i < 3) ? 1 : 0);
      if (i == 0) chk("fair_cchoice", int'(cchoice_o), 10);
    end

    // Asynchronous reset in the middle of the walk
    chk("mid_busy_before", int'(busy_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_restart", int'(restart_o), 0);
    chk("mid_busy", int'(busy_o), 0);
    chk("mid_done", int'(done_o), 0);
    chk("mid_pause", int'(pause_o), 0);
    chk("mid_cchoice", int'(cchoice_o), 0);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (restart_o || busy_o) n++;
    end
    chk("post_rst_idle_cycles", n, 0);
    pulse_start();
    chk("idle_start_restart", int'(restart_o), 1);
    chk("idle_start_rchoice", int'(rchoice_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
